rf_2p_arb: RTL and testbench

- Shares one two-port register file macro (1 read port, 1 write port, 1-cycle registered read) between NREQ requesters.
- Independent round-robin arbitration on the read port and the write port.
- Resolves same-address read/write collisions, which the macro returns as X, by deferring the read. A bounded counter prevents read starvation.
- Sits between PE-side buffer clients and the RF instance in the MEM subsystem.

---
 rtl/rf_2p_arb_if.sv | 39 +++
 rtl/rf_2p_arb.sv | 88 ++++++++
 tb/tb_rf_2p_arb.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_2p_arb_if.sv
// rf_2p_arb_if: requester-side and RF-side signal bundle for rf_2p_arb.
//   Requesters: i_rreq/i_raddr (read), i_wreq/i_waddr/i_wdata (write),
//               o_rgnt/o_wgnt (combinational grants), o_rvalid/o_rid/o_rdata (response).
//   RF macro:   o_rf_read/o_rf_raddr, o_rf_write/o_rf_waddr/o_rf_wdata, i_rf_rdata.
//   slave  = arbiter side, master = client/RF side.
interface rf_2p_arb_if #(
  parameter int NREQ = 4,
  parameter int AWD  = 6,
  parameter int DWD  = 16,
  parameter int IDWD = 2
);
  logic [NREQ-1:0]           i_rreq;
  logic [NREQ-1:0][AWD-1:0]  i_raddr;
  logic [NREQ-1:0]           o_rgnt;
  logic [NREQ-1:0]           i_wreq;
  logic [NREQ-1:0][AWD-1:0]  i_waddr;
  logic [NREQ-1:0][DWD-1:0]  i_wdata;
  logic [NREQ-1:0]           o_wgnt;
  logic                      o_rf_read;
  logic [AWD-1:0]            o_rf_raddr;
  logic                      o_rf_write;
  logic [AWD-1:0]            o_rf_waddr;
  logic [DWD-1:0]            o_rf_wdata;
  logic [DWD-1:0]            i_rf_rdata;
  logic                      o_rvalid;
  logic [IDWD-1:0]           o_rid;
  logic [DWD-1:0]            o_rdata;

  modport slave (
    input  i_rreq, i_raddr, i_wreq, i_waddr, i_wdata, i_rf_rdata,
    output o_rgnt, o_wgnt, o_rf_read, o_rf_raddr, o_rf_write, o_rf_waddr,
           o_rf_wdata, o_rvalid, o_rid, o_rdata
  );
  modport master (
    output i_rreq, i_raddr, i_wreq, i_waddr, i_wdata, i_rf_rdata,
    input  o_rgnt, o_wgnt, o_rf_read, o_rf_raddr, o_rf_write, o_rf_waddr,
           o_rf_wdata, o_rvalid, o_rid, o_rdata
  );
endinterface

// File: rtl/rf_2p_arb.sv
// rf_2p_arb: shares a 1R/1W register file (1-cycle registered read) among
// NREQ requesters. Independent round-robin arbiters on the read and write
// ports; a same-address read/write pair defers the read, at most COLLMAX
// times in a row, after which the read wins and the write waits.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-low reset
//   bus    : rf_2p_arb_if.slave (requests, grants, RF drive, read response)
module rf_2p_arb #(
  parameter int NREQ    = 4,
  parameter int WORDWD  = 48,
  parameter int DWD     = 16,
  parameter int AWD     = $clog2(WORDWD),
  parameter int IDWD    = $clog2(NREQ),
  parameter int COLLMAX = 3
) (
  input logic        i_clk,
  input logic        i_rst,
  rf_2p_arb_if.slave bus
);
  localparam int CCWD = $clog2(COLLMAX + 1);

  typedef struct packed {
    logic            found;
    logic [IDWD-1:0] idx;
  } pick_t;

  logic [IDWD-1:0] rptr, wptr;
  logic [CCWD-1:0] ccnt;
  pick_t           rp, wp;
  logic            collide, force_rd, rg, wg;

  // First requesting index at or after ptr, wrapping mod NREQ. Scanning from
  // the far end lets the nearest hit overwrite the others.
  function automatic pick_t pick(input logic [NREQ-1:0] req, input logic [IDWD-1:0] ptr);
    pick_t p;
    int    j;
    p = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (req[IDWD'(j)]) begin
        p.found = 1'b1;
        p.idx   = IDWD'(j);
      end
    end
    return p;
  endfunction

  // Explicit wrap keeps pointers < NREQ for non-power-of-2 NREQ.
  function automatic logic [IDWD-1:0] nxt(input logic [IDWD-1:0] idx);
    return (idx == IDWD'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    rp       = pick(bus.i_rreq, rptr);
    wp       = pick(bus.i_wreq, wptr);
    collide  = rp.found && wp.found && (bus.i_raddr[rp.idx] == bus.i_waddr[wp.idx]);
    force_rd = collide && (ccnt == CCWD'(COLLMAX));
    // Grants are held off entirely while reset is asserted.
    rg       = i_rst && rp.found && (!collide || force_rd);
    wg       = i_rst && wp.found && !force_rd;
  end

  assign bus.o_rgnt     = rg ? (NREQ'(1) << rp.idx) : '0;
  assign bus.o_wgnt     = wg ? (NREQ'(1) << wp.idx) : '0;
  assign bus.o_rf_read  = rg;
  assign bus.o_rf_raddr = rg ? bus.i_raddr[rp.idx] : '0;
  assign bus.o_rf_write = wg;
  assign bus.o_rf_waddr = wg ? bus.i_waddr[wp.idx] : '0;
  assign bus.o_rf_wdata = wg ? bus.i_wdata[wp.idx] : '0;
  assign bus.o_rdata    = bus.i_rf_rdata;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rptr         <= '0;
      wptr         <= '0;
      ccnt         <= '0;
      bus.o_rvalid <= 1'b0;
      bus.o_rid    <= '0;
    end else begin
      if (rg) rptr <= nxt(rp.idx);
      if (wg) wptr <= nxt(wp.idx);
      ccnt         <= (collide && !force_rd) ? ccnt + 1'b1 : '0;
      bus.o_rvalid <= rg;
      if (rg) bus.o_rid <= rp.idx;
    end
  end
endmodule

// File: tb/tb_rf_2p_arb.sv
// tb_rf_2p_arb: directed bench for rf_2p_arb with a behavioural RF model
// (registered read, X on same-address read/write).
module tb_rf_2p_arb;
  localparam int NREQ = 4;
  localparam int AWD  = 6;
  localparam int DWD  = 16;
  localparam int IDWD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   rfcoll = 0;
  logic [DWD-1:0] mem [0:47];

  rf_2p_arb_if #(.NREQ(NREQ), .AWD(AWD), .DWD(DWD), .IDWD(IDWD)) bus ();

  rf_2p_arb #(.NREQ(NREQ), .WORDWD(48), .DWD(DWD), .COLLMAX(3)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // RF macro model; reset loads known contents.
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 48; k++) mem[k] <= 16'h1000 + 16'(k);
      mem[5] <= 16'h1234;
    end else begin
      if (bus.o_rf_write) mem[bus.o_rf_waddr] <= bus.o_rf_wdata;
      if (bus.o_rf_read) begin
        if (bus.o_rf_write && bus.o_rf_waddr == bus.o_rf_raddr) begin
          bus.i_rf_rdata <= 'x;
          rfcoll <= rfcoll + 1;
        end else begin
          bus.i_rf_rdata <= mem[bus.o_rf_raddr];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    for (int k = 0; k < NREQ; k++) begin
      bus.i_raddr[k] = AWD'(30 + k);
      bus.i_waddr[k] = AWD'(10 + k);
      bus.i_wdata[k] = 16'hA000 + 16'(k);
    end
  endtask

  initial begin
    bus.i_rreq = '0;
    bus.i_wreq = '0;
    defaults();
    repeat (2) @(posedge clk);
    #1;
    // Reset: grants held off even with everything requesting.
    bus.i_wreq = '1;
    bus.i_rreq = '1;
    #1;
    chk("rst_wgnt", 32'(bus.o_wgnt), 0);
    chk("rst_rgnt", 32'(bus.o_rgnt), 0);
    chk("rst_rfw", 32'(bus.o_rf_write), 0);
    chk("rst_rfr", 32'(bus.o_rf_read), 0);
    chk("rst_rvalid", 32'(bus.o_rvalid), 0);
    chk("rst_rid", 32'(bus.o_rid), 0);
    bus.i_rreq = '0;
    rst = 1'b1;
    #1;

    // Write round-robin with all four requesting.
    for (int k = 0; k < 4; k++) begin
      chk("wrr_gnt", 32'(bus.o_wgnt), 32'(1) << k);
      chk("wrr_addr", 32'(bus.o_rf_waddr), 32'(10 + k));
      chk("wrr_data", 32'(bus.o_rf_wdata), 32'h0000A000 + 32'(k));
      cyc();
    end
    bus.i_wreq = '0;
    #1;
    chk("idle_wgnt", 32'(bus.o_wgnt), 0);
    chk("idle_rgnt", 32'(bus.o_rgnt), 0);
    chk("idle_rfw", 32'(bus.o_rf_write), 0);
    chk("idle_waddr", 32'(bus.o_rf_waddr), 0);
    chk("idle_wdata", 32'(bus.o_rf_wdata), 0);

    // Read latency and id: requester 2 reads addr 5.
    bus.i_raddr[2] = 6'd5;
    bus.i_rreq = 4'b0100;
    #1;
    chk("rd_gnt", 32'(bus.o_rgnt), 32'b0100);
    chk("rd_rfr", 32'(bus.o_rf_read), 1);
    chk("rd_raddr", 32'(bus.o_rf_raddr), 5);
    cyc();
    bus.i_rreq = '0;
    chk("rd_rvalid", 32'(bus.o_rvalid), 1);
    chk("rd_rid", 32'(bus.o_rid), 2);
    chk("rd_rdata", 32'(bus.o_rdata), 32'h1234);
    cyc();
    chk("rd_rvalid_drop", 32'(bus.o_rvalid), 0);

    // Collision: req0 writes 7, req1 reads 7 (wptr=0, rptr=3).
    bus.i_waddr[0] = 6'd7;
    bus.i_wdata[0] = 16'hBEEF;
    bus.i_wreq = 4'b0001;
    bus.i_raddr[1] = 6'd7;
    bus.i_rreq = 4'b0010;
    #1;
    chk("col_wgnt", 32'(bus.o_wgnt), 32'b0001);
    chk("col_rgnt", 32'(bus.o_rgnt), 0);
    chk("col_rfr", 32'(bus.o_rf_read), 0);
    cyc();
    bus.i_wreq = '0;
    #1;
    chk("col_rgnt2", 32'(bus.o_rgnt), 32'b0010);
    chk("col_raddr2", 32'(bus.o_rf_raddr), 7);
    cyc();
    bus.i_rreq = '0;
    chk("col_rvalid", 32'(bus.o_rvalid), 1);
    chk("col_rid", 32'(bus.o_rid), 1);
    chk("col_rdata", 32'(bus.o_rdata), 32'hBEEF);

    // Starvation bound: req1 reads 3, req0/req2 alternate writes to 3.
    bus.i_raddr[1] = 6'd3;
    bus.i_rreq = 4'b0010;
    bus.i_waddr[0] = 6'd3;
    bus.i_waddr[2] = 6'd3;
    bus.i_wdata[0] = 16'h0A01;
    bus.i_wreq = 4'b0001;
    #1;
    chk("stv1_wgnt", 32'(bus.o_wgnt), 32'b0001);
    chk("stv1_rgnt", 32'(bus.o_rgnt), 0);
    cyc();
    bus.i_wdata[2] = 16'h0B02;
    bus.i_wreq = 4'b0100;
    #1;
    chk("stv2_wgnt", 32'(bus.o_wgnt), 32'b0100);
    chk("stv2_rgnt", 32'(bus.o_rgnt), 0);
    cyc();
    bus.i_wdata[0] = 16'h0C03;
    bus.i_wreq = 4'b0001;
    #1;
    chk("stv3_wgnt", 32'(bus.o_wgnt), 32'b0001);
    chk("stv3_rgnt", 32'(bus.o_rgnt), 0);
    cyc();
    bus.i_wreq = 4'b0100;
    #1;
    chk("stv4_rgnt", 32'(bus.o_rgnt), 32'b0010);
    chk("stv4_wgnt", 32'(bus.o_wgnt), 0);
    chk("stv4_rfw", 32'(bus.o_rf_write), 0);
    chk("stv4_raddr", 32'(bus.o_rf_raddr), 3);
    cyc();
    bus.i_rreq = '0;
    #1;
    chk("stv_rvalid", 32'(bus.o_rvalid), 1);
    chk("stv_rid", 32'(bus.o_rid), 1);
    chk("stv_rdata", 32'(bus.o_rdata), 32'h0C03);
    chk("stv5_wgnt", 32'(bus.o_wgnt), 32'b0100);
    chk("stv5_waddr", 32'(bus.o_rf_waddr), 3);
    cyc();
    bus.i_wreq = '0;

    // Concurrent non-colliding: read 1, write 2 (rptr=2, wptr=3).
    bus.i_raddr[0] = 6'd1;
    bus.i_rreq = 4'b0001;
    bus.i_waddr[3] = 6'd2;
    bus.i_wdata[3] = 16'h5555;
    bus.i_wreq = 4'b1000;
    #1;
    chk("cc_rgnt", 32'(bus.o_rgnt), 32'b0001);
    chk("cc_wgnt", 32'(bus.o_wgnt), 32'b1000);
    chk("cc_rfr", 32'(bus.o_rf_read), 1);
    chk("cc_rfw", 32'(bus.o_rf_write), 1);
    chk("cc_raddr", 32'(bus.o_rf_raddr), 1);
    chk("cc_waddr", 32'(bus.o_rf_waddr), 2);
    cyc();
    bus.i_rreq = '0;
    bus.i_wreq = '0;
    chk("cc_rvalid", 32'(bus.o_rvalid), 1);
    chk("cc_rid", 32'(bus.o_rid), 0);
    chk("cc_rdata", 32'(bus.o_rdata), 32'h1001);

    // Reset mid-operation: pointers moved off zero, read in flight.
    bus.i_rreq = 4'b0001;
    bus.i_waddr[1] = 6'd20;
    bus.i_wreq = 4'b0010;
    #1;
    chk("rm_rgnt", 32'(bus.o_rgnt), 32'b0001);
    chk("rm_wgnt", 32'(bus.o_wgnt), 32'b0010);
    cyc();
    bus.i_rreq = '0;
    bus.i_wreq = '0;
    rst = 1'b0;
    #1;
    chk("rm_rvalid", 32'(bus.o_rvalid), 0);
    chk("rm_rid", 32'(bus.o_rid), 0);
    defaults();
    bus.i_wreq = '1;
    bus.i_rreq = '1;
    #1;
    chk("rm_wgnt_rst", 32'(bus.o_wgnt), 0);
    chk("rm_rgnt_rst", 32'(bus.o_rgnt), 0);
    cyc();
    rst = 1'b1;
    #1;
    chk("rm_wgnt_rel", 32'(bus.o_wgnt), 32'b0001);
    chk("rm_rgnt_rel", 32'(bus.o_rgnt), 32'b0001);
    chk("rm_waddr_rel", 32'(bus.o_rf_waddr), 10);
    chk("rm_raddr_rel", 32'(bus.o_rf_raddr), 30);
    chk("rm_rvalid_rel", 32'(bus.o_rvalid), 0);
    cyc();
    chk("rm_wgnt_nxt", 32'(bus.o_wgnt), 32'b0010);
    chk("rm_rgnt_nxt", 32'(bus.o_rgnt), 32'b0010);
    chk("rm_rid_nxt", 32'(bus.o_rid), 0);
    bus.i_wreq = '0;
    bus.i_rreq = '0;
    cyc();
    chk("rf_no_same_addr", 32'(rfcoll), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
